iter_multiplier_8x8b: RTL and testbench

ITER_MULTIPLIER_8X8B -- requirements
Module: iter_multiplier_8x8b

---
 rtl/iter_multiplier_8x8b_pkg.sv | 15 +
 rtl/partial_product_1x8b.sv | 12 +
 rtl/iter_multiplier_8x8b.sv | 102 ++++++++++
 tb/tb_iter_multiplier_8x8b.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/iter_multiplier_8x8b_pkg.sv
// Shared types and constants for the 8x8 iterative shift-add multiplier.
package iter_multiplier_8x8b_pkg;

  localparam int OPND_W    = 8;
  localparam int PROD_W    = 16;
  localparam int NUM_STEPS = 8;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/partial_product_1x8b.sv
// One row of the shift-add multiplier: an 8-bit operand gated by a single select bit.
module partial_product_1x8b
  import iter_multiplier_8x8b_pkg::*;
(
  input  logic [OPND_W-1:0] opnd,
  input  logic              sel,
  output logic [OPND_W-1:0] pp
);

  assign pp = opnd & {OPND_W{sel}};

endmodule

// File: rtl/iter_multiplier_8x8b.sv
// Unsigned 8x8 multiplier, one shift-add step per cycle, fixed 8-cycle CALC phase.
// Handshake: a transfer happens on a rising edge where val and rdy of the same
// stream are both 1; rdy/val are pure functions of the FSM state (no comb path).
module iter_multiplier_8x8b
  import iter_multiplier_8x8b_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              istream_val,
  output logic              istream_rdy,
  input  logic [OPND_W-1:0] in0,
  input  logic [OPND_W-1:0] in1,
  output logic              ostream_val,
  input  logic              ostream_rdy,
  output logic [PROD_W-1:0] prod,
  output logic [1:0]        state_dbg
);

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [OPND_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   pp;

  // The 16-bit shifted multiplicand is gated as two byte-wide rows.
  partial_product_1x8b u_pp_lo (
    .opnd (mcand_q[OPND_W-1:0]),
    .sel  (mplier_q[0]),
    .pp   (pp[OPND_W-1:0])
  );

  partial_product_1x8b u_pp_hi (
    .opnd (mcand_q[PROD_W-1:OPND_W]),
    .sel  (mplier_q[0]),
    .pp   (pp[PROD_W-1:OPND_W])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (istream_val) state_d = CALC;
      CALC: if (cnt_q == CNT_W'(NUM_STEPS - 1)) state_d = DONE;
      DONE: if (ostream_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (istream_val) begin
          mcand_d  = {{(PROD_W - OPND_W){1'b0}}, in0};
          mplier_d = in1;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      CALC: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      DONE: ;
      default: begin
        mcand_d  = '0;
        acc_d    = '0;
        mplier_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    istream_rdy = (state_q == IDLE);
    ostream_val = (state_q == DONE);
    prod        = acc_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_iter_multiplier_8x8b.sv
// Bench for iter_multiplier_8x8b: directed corner cases, reset abort, back-to-back and random traffic.
module tb_iter_multiplier_8x8b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        istream_val;
  logic        istream_rdy;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [15:0] prod;
  logic [1:0]  state_dbg;

  iter_multiplier_8x8b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .in0         (in0),
    .in1         (in1),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .prod        (prod),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_q[$];
  int          acc_cyc_q[$];
  int          rdy_mode = 0;
  bit          b2b = 1'b0;
  int          last_acc = -1;
  bit          prev_val = 1'b0;
  bit          check_idle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
  endtask

  // Random consumer back-pressure when enabled.
  always @(posedge clk) begin
    if (rdy_mode == 1) begin
      #1 ostream_rdy = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit keep_val);
    bit got = 1'b0;
    logic [15:0] e;
    @(posedge clk); #1;
    istream_val = 1'b1;
    in0 = a;
    in1 = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (istream_rdy) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_timeout", 32'(got), 32'd1);
    if (got) begin
      e = 16'(int'(a) * int'(b));
      exp_q.push_back(e);
      acc_cyc_q.push_back(cycle + 1);
      if (b2b && last_acc >= 0) chk("b2b_spacing", cycle + 1 - last_acc, 32'd10);
      last_acc = cycle + 1;
    end
    @(posedge clk); #1;
    istream_val = keep_val;
    in0 = 8'($urandom);
    in1 = 8'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_val   = 1'b0;
      check_idle = 1'b0;
    end else begin
      if (ostream_val) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(ostream_val), 32'd0);
        end else begin
          if (!prev_val) chk("latency", cycle - acc_cyc_q[0], 32'd8);
          chk("prod", 32'(prod), 32'(exp_q[0]));
          chk("istream_rdy_in_done", 32'(istream_rdy), 32'd0);
          if (ostream_rdy) begin
            void'(exp_q.pop_front());
            void'(acc_cyc_q.pop_front());
            check_idle = 1'b1;
          end
        end
      end else if (check_idle) begin
        chk("rdy_after_consume", 32'(istream_rdy), 32'd1);
        check_idle = 1'b0;
      end
      prev_val = ostream_val;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n       = 1'b0;
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    in0         = 8'd0;
    in1         = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_istream_rdy", 32'(istream_rdy), 32'd1);
    chk("reset_ostream_val", 32'(ostream_val), 32'd0);
    chk("reset_prod", 32'(prod), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;

    // Directed corner operands
    ostream_rdy = 1'b1;
    send(8'd3, 8'd5, 1'b0);
    send(8'd255, 8'd255, 1'b0);
    send(8'd0, 8'd200, 1'b0);
    send(8'd200, 8'd0, 1'b0);
    drain();

    // Consumer stall in DONE for 5 cycles
    ostream_rdy = 1'b0;
    send(8'd12, 8'd10, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ostream_val) break;
    end
    chk("stall_val_seen", 32'(ostream_val), 32'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    ostream_rdy = 1'b1;
    drain();

    // Reset in the middle of CALC discards the pending result
    send(8'd7, 8'd9, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_istream_rdy", 32'(istream_rdy), 32'd1);
    chk("abort_ostream_val", 32'(ostream_val), 32'd0);
    chk("abort_prod", 32'(prod), 32'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    last_acc = -1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1 chk("abort_no_result", 32'(ostream_val), 32'd0);

    // Back-to-back with both sides always ready
    b2b      = 1'b1;
    last_acc = -1;
    send(8'd1, 8'd1, 1'b1);
    send(8'd128, 8'd2, 1'b1);
    send(8'd17, 8'd15, 1'b0);
    b2b = 1'b0;
    drain();

    // Random operands with random back-pressure
    rdy_mode = 1;
    repeat (20) send(8'($urandom), 8'($urandom), 1'b0);
    drain();
    rdy_mode = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
